multu_sched: RTL and testbench
==============================

# multu_sched

Round-robin scheduler that shares one sequential unsigned multiplier (`multu`) between NREQ requesters. It captures a winning requester's operands, starts the multiplier with a one-cycle `doMult` pulse, and waits for the rising edge of `mult_done`. It then returns the 32-bit product to the owner with a one-cycle valid, or an error if a watchdog expires. It sits between the datapath clients and the single `multu` instance.

## Interface
- NREQ, 4: number of requesters (2..8)
- TIMEOUT, 64: maximum WAIT cycles before abort (1..255)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  level request per requester
- a_in  in  32*NREQ  operand A, requester i at [32i+31:32i]
- b_in  in  32*NREQ  operand B, same packing
- grant  out  NREQ  one-hot, 1-cycle pulse: operands captured
- done  out  NREQ  one-hot, 1-cycle pulse marking the result owner
- result  out  32  product (0 on error), held until next DELIVER
- result_valid  out  1  1-cycle pulse with `done`
- result_err  out  1  high with result_valid when timed out
- busy  out  1  state != IDLE
- mult_a, mult_b  out  32  to multu a/b, stable from ISSUE through WAIT
- mult_go  out  1  to multu doMult
- mult_reset  out  1  to multu reset (active-high)
- mult_out  in  32  from multu out
- mult_done  in  1  from multu mult_done

## Operation
- States: IDLE, ISSUE, WAIT, DELIVER. All outputs are registered.
- IDLE:
  - If any `req` bit is high, pick the winner by round-robin: search ptr+1, ptr+2, … modulo NREQ.
  - Latch that requester's slices into mult_a/mult_b, set `grant` one-hot, set mult_go=1, then go to ISSUE.
- ISSUE (1 cycle): grant and mult_go are high. Clear the counter, then go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - Completion is mult_done=1 while the previous-cycle sampled mult_done=0 (rising edge). On completion, result<=mult_out, err<=0, go to DELIVER.
  - If the counter reaches TIMEOUT with no completion: result<=0, err<=1, mult_reset<=1 for one cycle, go to DELIVER.
- DELIVER (1 cycle): result_valid=1, done=one-hot of the owner, result_err=err. Set ptr<=owner, then go to IDLE.
- Product width: `result` is mult_out passed through unchanged, with no truncation or extension by this block.
- Requester rule:
  - Operands need to be valid only in the cycle `req` is sampled in IDLE.
  - A requester drops `req` the cycle after `grant`. If `req` is still high at the next IDLE, it is treated as a new request.
- Requests arriving while busy are not lost (level-held) and are arbitrated in the next IDLE.

## Timing
- Reset values: grant=0, done=0, result=0, result_valid=0, result_err=0, busy=0, mult_a=0, mult_b=0, mult_go=0, mult_reset=1, ptr=NREQ-1 (requester 0 has first priority), state=IDLE.
- mult_reset deasserts on the first clk edge after reset releases.
- req sampled in IDLE at edge k: grant and mult_go are high in cycle k+1, and WAIT starts at cycle k+2.
- mult_done rising edge sampled at edge m: result_valid is high in cycle m+1. Total latency = multu latency + 3 cycles.
- Back-to-back: IDLE occupies ≥1 cycle between transactions.
- mult_done high in IDLE, ISSUE, or DELIVER is ignored (stale done). Only a 0→1 edge observed in WAIT completes.
- Completion and timeout in the same cycle: completion wins, err=0, and no mult_reset pulse.
- Multiple simultaneous requests: exactly one grant. The others are served in round-robin order.
- Reset asserted mid-transaction (any state): immediate return to reset values. No done or result_valid is produced for the in-flight request, and mult_reset is high while reset is asserted.

## Test plan
- Single request: req[0] with A=0x17, B=0x3 → grant[0] one cycle later, one mult_go pulse, then result=0x45, done[0], result_valid, result_err=0.
- Two simultaneous requests: req[0] (0x17×0x3) and req[2] (0x3×0x69), both high → grant[0] first, result 0x45 on done[0]; then grant[2], result 0x13B on done[2].
- Fairness: all four req held high continuously → grant order 0,1,2,3,0. No requester is granted twice before all others.
- Timeout: stub multu never raises mult_done, TIMEOUT=64 → result_valid with result_err=1, result=0, and a one-cycle mult_reset pulse. A following request completes normally.
- Stale done: mult_done held high in IDLE, then req[1] 0x3×0x69 → mult_done ignored until it falls and rises in WAIT. Result is 0x13B, not the stale mult_out.
- Reset mid-WAIT: assert reset 10 cycles into WAIT → outputs go to reset values and no result_valid is produced. After release, req[3] 0x17×0x3 returns 0x45.

Source files
------------

// File: rtl/multu_sched_if.sv
// Signal bundle between multu_sched, its requesters and the shared multu.
// master: the scheduler side. slave: requesters plus the multiplier.
interface multu_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [32*NREQ-1:0] a_in;
  logic [32*NREQ-1:0] b_in;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [31:0]        result;
  logic               result_valid;
  logic               result_err;
  logic               busy;
  logic [31:0]        mult_a;
  logic [31:0]        mult_b;
  logic               mult_go;
  logic               mult_reset;
  logic [31:0]        mult_out;
  logic               mult_done;

  modport master (
    input  req, a_in, b_in, mult_out, mult_done,
    output grant, done, result, result_valid, result_err, busy,
           mult_a, mult_b, mult_go, mult_reset
  );

  modport slave (
    output req, a_in, b_in, mult_out, mult_done,
    input  grant, done, result, result_valid, result_err, busy,
           mult_a, mult_b, mult_go, mult_reset
  );
endinterface

// File: rtl/multu_sched.sv
// Round-robin scheduler sharing one sequential multiplier between NREQ
// requesters. Grants one requester, issues the operands with a doMult
// pulse, waits for a rising mult_done (or a watchdog) and returns the
// product to the owner. Every output comes straight from a register.
module multu_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           reset,
  multu_sched_if.master bus
);
  localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]      TO_LIMIT = 8'(TIMEOUT);
  localparam logic [PW-1:0]   PTR_INIT = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_LSB  = NREQ'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic            r_done_d;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic [31:0]     r_result, w_result_nxt;
  logic            r_result_valid, w_result_valid_nxt;
  logic            r_result_err, w_result_err_nxt;
  logic            r_busy, w_busy_nxt;
  logic [31:0]     r_mult_a, w_mult_a_nxt;
  logic [31:0]     r_mult_b, w_mult_b_nxt;
  logic            r_mult_go, w_mult_go_nxt;
  logic            r_mult_reset, w_mult_reset_nxt;

  logic            w_found;
  logic [PW-1:0]   w_pick;
  logic            w_mult_rise;
  logic [7:0]      w_cnt_inc;

  // Round-robin search starting one past the last owner; returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] req_v,
                                          input logic [PW-1:0]   ptr_v);
    logic          found;
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    found = 1'b0;
    pick  = ptr_v;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(ptr_v) + i) % NREQ);
      if (!found && req_v[idx]) begin
        found = 1'b1;
        pick  = idx;
      end else begin
        found = found;
      end
    end
    return {found, pick};
  endfunction

  assign {w_found, w_pick} = rr_pick(bus.req, r_ptr);
  // Only a 0->1 transition counts, so a done left high from earlier is ignored.
  assign w_mult_rise = bus.mult_done & ~r_done_d;
  assign w_cnt_inc   = r_cnt + 8'd1;

  // Next-state and next-output decode; pulses default low every cycle.
  always_comb begin
    w_state_nxt        = r_state;
    w_ptr_nxt          = r_ptr;
    w_owner_nxt        = r_owner;
    w_cnt_nxt          = r_cnt;
    w_grant_nxt        = {NREQ{1'b0}};
    w_done_nxt         = {NREQ{1'b0}};
    w_result_nxt       = r_result;
    w_result_valid_nxt = 1'b0;
    w_result_err_nxt   = 1'b0;
    w_mult_a_nxt       = r_mult_a;
    w_mult_b_nxt       = r_mult_b;
    w_mult_go_nxt      = 1'b0;
    w_mult_reset_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nxt   = w_pick;
          w_grant_nxt   = ONE_LSB << w_pick;
          w_mult_a_nxt  = bus.a_in[{w_pick, 5'd0} +: 32];
          w_mult_b_nxt  = bus.b_in[{w_pick, 5'd0} +: 32];
          w_mult_go_nxt = 1'b1;
          w_state_nxt   = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        // Completion is checked first so it wins over a same-cycle timeout.
        if (w_mult_rise) begin
          w_result_nxt       = bus.mult_out;
          w_result_valid_nxt = 1'b1;
          w_done_nxt         = ONE_LSB << r_owner;
          w_state_nxt        = S_DELIVER;
        end else if (w_cnt_inc == TO_LIMIT) begin
          w_result_nxt       = 32'd0;
          w_result_valid_nxt = 1'b1;
          w_result_err_nxt   = 1'b1;
          w_done_nxt         = ONE_LSB << r_owner;
          w_mult_reset_nxt   = 1'b1;
          w_state_nxt        = S_DELIVER;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DELIVER: begin
        w_ptr_nxt   = r_owner;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers; reset holds the multiplier in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_ptr          <= PTR_INIT;
      r_owner        <= {PW{1'b0}};
      r_cnt          <= 8'd0;
      r_done_d       <= 1'b0;
      r_grant        <= {NREQ{1'b0}};
      r_done         <= {NREQ{1'b0}};
      r_result       <= 32'd0;
      r_result_valid <= 1'b0;
      r_result_err   <= 1'b0;
      r_busy         <= 1'b0;
      r_mult_a       <= 32'd0;
      r_mult_b       <= 32'd0;
      r_mult_go      <= 1'b0;
      r_mult_reset   <= 1'b1;
    end else begin
      r_state        <= w_state_nxt;
      r_ptr          <= w_ptr_nxt;
      r_owner        <= w_owner_nxt;
      r_cnt          <= w_cnt_nxt;
      r_done_d       <= bus.mult_done;
      r_grant        <= w_grant_nxt;
      r_done         <= w_done_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_result_err   <= w_result_err_nxt;
      r_busy         <= w_busy_nxt;
      r_mult_a       <= w_mult_a_nxt;
      r_mult_b       <= w_mult_b_nxt;
      r_mult_go      <= w_mult_go_nxt;
      r_mult_reset   <= w_mult_reset_nxt;
    end
  end

  assign bus.grant        = r_grant;
  assign bus.done         = r_done;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.result_err   = r_result_err;
  assign bus.busy         = r_busy;
  assign bus.mult_a       = r_mult_a;
  assign bus.mult_b       = r_mult_b;
  assign bus.mult_go      = r_mult_go;
  assign bus.mult_reset   = r_mult_reset;
endmodule

// File: tb/tb_multu_sched.sv
// Testbench for multu_sched: a behavioural multu stub plus directed and
// randomized scenarios checked against an arbitration/product model.
module tb_multu_sched;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic [NREQ-1:0] g;
    logic            go;
    logic [NREQ-1:0] d;
    logic [31:0]     r;
    logic            e;
    logic            mr;
    logic            v_after;
    logic            mr_after;
    int              lat;
  } txn_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          mdl_ptr = NREQ - 1;
  bit          hold_req = 1'b0;
  logic [31:0] oa [NREQ];
  logic [31:0] ob [NREQ];

  // multu stub controls and state
  int          m_lat = 4;
  int          m_drop = 0;
  bit          m_hang = 1'b0;
  bit          m_stale = 1'b0;
  logic [31:0] m_a, m_b;
  int          m_cnt;
  bit          m_busy;

  localparam logic [108:0] RST_EXP = {4'b0, 4'b0, 32'b0, 1'b0, 1'b0, 1'b0,
                                      32'b0, 32'b0, 1'b0, 1'b1};

  multu_sched_if #(.NREQ(NREQ)) bus ();

  multu_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Sequential multiplier stub: done rises m_lat edges after doMult is seen;
  // m_drop delays the fall of a previously high done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_cnt <= 0;
      bus.mult_done <= 1'b0; bus.mult_out <= 32'd0;
    end else if (bus.mult_reset) begin
      m_busy <= 1'b0; bus.mult_done <= 1'b0;
    end else if (m_stale) begin
      bus.mult_done <= 1'b1; bus.mult_out <= 32'hDEADBEEF;
    end else if (bus.mult_go) begin
      m_a <= bus.mult_a; m_b <= bus.mult_b; m_cnt <= 1; m_busy <= 1'b1;
      if (m_drop == 0) bus.mult_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt >= m_drop) bus.mult_done <= 1'b0;
      if (!m_hang && m_cnt == m_lat) begin
        bus.mult_done <= 1'b1; bus.mult_out <= m_a * m_b; m_busy <= 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---- reference model ----
  function automatic int mdl_pick(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(mdl_ptr + k) % NREQ]) return (mdl_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  // expected {grant, go, done, result, err, mult_reset, valid_after, mult_reset_after}
  function automatic logic [44:0] pack_exp(input int owner, input logic [31:0] res,
                                           input logic err);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << owner;
    return {oh, 1'b1, oh, res, err, err, 1'b0, 1'b0};
  endfunction

  function automatic logic [44:0] pack_obs(input txn_t t);
    return {t.g, t.go, t.d, t.r, t.e, t.mr, t.v_after, t.mr_after};
  endfunction

  function automatic logic [108:0] rst_view();
    return {bus.grant, bus.done, bus.result, bus.result_valid, bus.result_err,
            bus.busy, bus.mult_a, bus.mult_b, bus.mult_go, bus.mult_reset};
  endfunction

  // ---- stimulus helpers (no checking) ----
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.a_in[32*i +: 32] = a;
    bus.b_in[32*i +: 32] = b;
    oa[i] = a;
    ob[i] = b;
    bus.req[i] = 1'b1;
  endtask

  // Waits for a grant, then for result_valid; lat = negedges from grant to valid.
  task automatic observe(output txn_t t);
    t.g = '0; t.go = 1'b0; t.d = '0; t.r = '0; t.e = 1'b0; t.mr = 1'b0;
    t.v_after = 1'b0; t.mr_after = 1'b0; t.lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        t.g = bus.grant; t.go = bus.mult_go;
        if (!hold_req) bus.req = bus.req & ~bus.grant;
        break;
      end
    end
    if (t.g == '0) return;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        t.lat = n; t.d = bus.done; t.r = bus.result;
        t.e = bus.result_err; t.mr = bus.mult_reset;
        @(negedge clk);
        t.v_after = bus.result_valid; t.mr_after = bus.mult_reset;
        break;
      end
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (rst_view() !== RST_EXP) begin
      errors++; $display("FAIL reset_values: got %h expected %h", rst_view(), RST_EXP);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mult_reset, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL reset_release: got %b expected 00", {bus.mult_reset, bus.busy});
    end
  endtask

  task automatic test_two();
    txn_t t;
    m_lat = 4;
    set_req(0, 32'h17, 32'h3);
    set_req(2, 32'h3, 32'h69);
    observe(t);
    checks++;
    if (pack_obs(t) !== pack_exp(0, 32'h45, 1'b0)) begin
      errors++; $display("FAIL two_first: got %h expected %h", pack_obs(t), pack_exp(0, 32'h45, 1'b0));
    end
    checks++;
    if (t.lat != m_lat + 2) begin
      errors++; $display("FAIL two_first_lat: got %0d expected %0d", t.lat, m_lat + 2);
    end
    mdl_ptr = 0;
    observe(t);
    checks++;
    if (pack_obs(t) !== pack_exp(2, 32'h13B, 1'b0)) begin
      errors++; $display("FAIL two_second: got %h expected %h", pack_obs(t), pack_exp(2, 32'h13B, 1'b0));
    end
    mdl_ptr = 2;
  endtask

  task automatic test_single();
    txn_t t;
    m_lat = 2;
    set_req(0, 32'h17, 32'h3);
    observe(t);
    checks++;
    if (pack_obs(t) !== pack_exp(0, 32'h45, 1'b0)) begin
      errors++; $display("FAIL single: got %h expected %h", pack_obs(t), pack_exp(0, 32'h45, 1'b0));
    end
    checks++;
    if (t.lat != m_lat + 2) begin
      errors++; $display("FAIL single_lat: got %0d expected %0d", t.lat, m_lat + 2);
    end
    mdl_ptr = 0;
  endtask

  task automatic test_stale();
    txn_t t;
    m_stale = 1'b1;
    @(negedge clk);
    m_stale = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.result_valid, bus.done} !== 6'b0) begin
      errors++; $display("FAIL stale_idle: got %b expected 000000", {bus.busy, bus.result_valid, bus.done});
    end
    m_drop = 3; m_lat = 6;
    set_req(1, 32'h3, 32'h69);
    observe(t);
    checks++;
    if (pack_obs(t) !== pack_exp(1, 32'h13B, 1'b0)) begin
      errors++; $display("FAIL stale_result: got %h expected %h", pack_obs(t), pack_exp(1, 32'h13B, 1'b0));
    end
    checks++;
    if (t.lat != m_lat + 2) begin
      errors++; $display("FAIL stale_lat: got %0d expected %0d", t.lat, m_lat + 2);
    end
    m_drop = 0;
    mdl_ptr = 1;
  endtask

  task automatic test_timeout();
    txn_t t;
    m_hang = 1'b1;
    set_req(2, $urandom, $urandom);
    observe(t);
    checks++;
    if (pack_obs(t) !== pack_exp(2, 32'h0, 1'b1)) begin
      errors++; $display("FAIL timeout_result: got %h expected %h", pack_obs(t), pack_exp(2, 32'h0, 1'b1));
    end
    checks++;
    if (t.lat != TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_lat: got %0d expected %0d", t.lat, TIMEOUT + 1);
    end
    mdl_ptr = 2;
    m_hang = 1'b0; m_lat = 3;
    set_req(3, 32'h17, 32'h3);
    observe(t);
    checks++;
    if (pack_obs(t) !== pack_exp(3, 32'h45, 1'b0)) begin
      errors++; $display("FAIL timeout_recover: got %h expected %h", pack_obs(t), pack_exp(3, 32'h45, 1'b0));
    end
    mdl_ptr = 3;
  endtask

  task automatic test_race();
    txn_t t;
    m_lat = TIMEOUT - 1;
    set_req(0, 32'h1234, 32'h10);
    observe(t);
    checks++;
    if (pack_obs(t) !== pack_exp(0, prod(32'h1234, 32'h10), 1'b0)) begin
      errors++; $display("FAIL race_complete: got %h expected %h", pack_obs(t), pack_exp(0, prod(32'h1234, 32'h10), 1'b0));
    end
    checks++;
    if (t.lat != TIMEOUT + 1) begin
      errors++; $display("FAIL race_complete_lat: got %0d expected %0d", t.lat, TIMEOUT + 1);
    end
    mdl_ptr = 0;
    m_lat = TIMEOUT;
    set_req(1, 32'h55, 32'h2);
    observe(t);
    checks++;
    if (pack_obs(t) !== pack_exp(1, 32'h0, 1'b1)) begin
      errors++; $display("FAIL race_late: got %h expected %h", pack_obs(t), pack_exp(1, 32'h0, 1'b1));
    end
    mdl_ptr = 1;
  endtask

  task automatic test_reset_mid();
    txn_t t;
    bit   got_grant;
    int   viol;
    m_lat = 100;
    got_grant = 1'b0;
    set_req(0, 32'h17, 32'h3);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.grant != '0) begin got_grant = 1'b1; break; end
    end
    bus.req = '0;
    checks++;
    if (!got_grant) begin
      errors++; $display("FAIL midrst_grant: got none expected grant");
    end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rst_view() !== RST_EXP) begin
      errors++; $display("FAIL midrst_values: got %h expected %h", rst_view(), RST_EXP);
    end
    viol = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.result_valid || bus.done != '0 || !bus.mult_reset) viol++;
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL midrst_hold: got %0d bad cycles expected 0", viol);
    end
    rst_n = 1'b1;
    mdl_ptr = NREQ - 1;
    m_lat = 3;
    @(negedge clk);
    checks++;
    if ({bus.mult_reset, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL midrst_release: got %b expected 00", {bus.mult_reset, bus.busy});
    end
    set_req(3, 32'h17, 32'h3);
    observe(t);
    checks++;
    if (pack_obs(t) !== pack_exp(3, 32'h45, 1'b0)) begin
      errors++; $display("FAIL midrst_after: got %h expected %h", pack_obs(t), pack_exp(3, 32'h45, 1'b0));
    end
    mdl_ptr = 3;
  endtask

  task automatic test_fairness();
    txn_t t;
    int   exp_o;
    m_lat = 3;
    hold_req = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 2), 32'(i + 5));
    for (int k = 0; k < 5; k++) begin
      exp_o = mdl_pick(bus.req);
      observe(t);
      checks++;
      if (pack_obs(t) !== pack_exp(exp_o, prod(oa[exp_o], ob[exp_o]), 1'b0)) begin
        errors++; $display("FAIL fair_%0d: got %h expected %h", k, pack_obs(t), pack_exp(exp_o, prod(oa[exp_o], ob[exp_o]), 1'b0));
      end
      mdl_ptr = exp_o;
      if (k == 4) bus.req = '0;
    end
    hold_req = 1'b0;
    checks++;
    if (mdl_ptr != 0) begin
      errors++; $display("FAIL fair_order: got last owner %0d expected 0", mdl_ptr);
    end
  endtask

  task automatic test_random();
    txn_t            t;
    int              exp_o;
    logic [NREQ-1:0] newb;
    for (int k = 0; k < 20; k++) begin
      newb = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~bus.req;
      if ((bus.req | newb) == '0) newb = NREQ'(1) << $urandom_range(0, NREQ - 1);
      for (int i = 0; i < NREQ; i++) begin
        if (newb[i]) set_req(i, $urandom, $urandom);
      end
      m_lat = $urandom_range(1, 12);
      exp_o = mdl_pick(bus.req);
      observe(t);
      checks++;
      if (pack_obs(t) !== pack_exp(exp_o, prod(oa[exp_o], ob[exp_o]), 1'b0) || t.lat != m_lat + 2) begin
        errors++; $display("FAIL rand_%0d: got %h lat %0d expected %h lat %0d", k, pack_obs(t), t.lat, pack_exp(exp_o, prod(oa[exp_o], ob[exp_o]), 1'b0), m_lat + 2);
      end
      mdl_ptr = exp_o;
    end
    bus.req = '0;
  endtask

  initial begin
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    test_reset();
    test_two();
    test_single();
    test_stale();
    test_timeout();
    test_race();
    test_reset_mid();
    test_fairness();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
